reg_bus_master: RTL

REG_BUS_MASTER -- requirements
Module: reg_bus_master

---
 rtl/reg_bus_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/reg_bus_master.sv
// Command-driven master for a simple chip-select register bus: single writes,
// single reads, and polled reads that repeat until a masked match or a read limit.
module reg_bus_master #(
    parameter int POLL_LIMIT = 1023,
    parameter int POLL_GAP   = 4
) (
    input  logic        Clk_reg,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_poll,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [15:0] cmd_mask,
    input  logic [15:0] cmd_match,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        CSB,
    output logic        WRB,
    output logic [7:0]  CA,
    output logic [15:0] CD_in,
    input  logic [15:0] CD_out,
    output logic [2:0]  state_dbg
);

    // Handshake: a command is taken on a rising edge where cmd_valid=1 and
    // cmd_ready=1; cmd_ready is high only in IDLE. Responses are a one-cycle
    // rsp_valid pulse with no back-pressure.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        GAP     = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t      state, state_d;
    logic        ready_q, ready_d;
    logic        csb_q, csb_d;
    logic        wrb_q, wrb_d;
    logic [7:0]  ca_q, ca_d;
    logic [15:0] cd_q, cd_d;
    logic [15:0] mask_q, mask_d;
    logic [15:0] match_q, match_d;
    logic        poll_q, poll_d;
    logic [15:0] poll_cnt, poll_cnt_d;
    logic [7:0]  gap_cnt, gap_cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rdata_q, rdata_d;
    logic        timeout_q, timeout_d;

    logic        accept;
    logic        hit;
    logic        last_read;

    always_comb begin
        state_d    = state;
        ca_d       = ca_q;
        cd_d       = cd_q;
        mask_d     = mask_q;
        match_d    = match_q;
        poll_d     = poll_q;
        poll_cnt_d = poll_cnt;
        gap_cnt_d  = gap_cnt;
        rdata_d    = rdata_q;
        timeout_d  = timeout_q;

        accept    = cmd_valid && ready_q;
        hit       = ((CD_out & mask_q) == match_q);
        last_read = ((poll_cnt + 16'd1) == 16'(POLL_LIMIT));

        case (state)
            IDLE: begin
                if (accept) begin
                    state_d    = cmd_write ? WRITE : READ;
                    ca_d       = cmd_addr;
                    cd_d       = cmd_wdata;
                    mask_d     = cmd_mask;
                    match_d    = cmd_match;
                    poll_d     = cmd_poll && !cmd_write;
                    poll_cnt_d = 16'd0;
                    if (cmd_write) begin
                        rdata_d   = 16'd0;
                        timeout_d = 1'b0;
                    end
                end
            end
            WRITE: state_d = RESP;
            READ:  state_d = CAPTURE;
            CAPTURE: begin
                rdata_d    = CD_out;
                poll_cnt_d = poll_cnt + 16'd1;
                if (!poll_q || hit) begin
                    state_d   = RESP;
                    timeout_d = 1'b0;
                end else if (last_read) begin
                    state_d   = RESP;
                    timeout_d = 1'b1;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = 8'd0;
                end
            end
            GAP: begin
                if (gap_cnt == 8'(POLL_GAP - 1)) begin
                    state_d = READ;
                end else begin
                    gap_cnt_d = gap_cnt + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus and handshake outputs are registered images of the next state.
        csb_d       = !((state_d == WRITE) || (state_d == READ));
        wrb_d       = (state_d != WRITE);
        rsp_valid_d = (state_d == RESP);
        ready_d     = (state_d == IDLE);
    end

    always_ff @(posedge Clk_reg) begin
        if (Reset) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            csb_q       <= 1'b1;
            wrb_q       <= 1'b1;
            ca_q        <= 8'd0;
            cd_q        <= 16'd0;
            mask_q      <= 16'd0;
            match_q     <= 16'd0;
            poll_q      <= 1'b0;
            poll_cnt    <= 16'd0;
            gap_cnt     <= 8'd0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_d;
            ready_q     <= ready_d;
            csb_q       <= csb_d;
            wrb_q       <= wrb_d;
            ca_q        <= ca_d;
            cd_q        <= cd_d;
            mask_q      <= mask_d;
            match_q     <= match_d;
            poll_q      <= poll_d;
            poll_cnt    <= poll_cnt_d;
            gap_cnt     <= gap_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            timeout_q   <= timeout_d;
        end
    end

    // ready_q comes out of reset high so the first idle cycle after release can accept.
    assign cmd_ready   = ready_q && !Reset;
    assign CSB         = csb_q;
    assign WRB         = wrb_q;
    assign CA          = ca_q;
    assign CD_in       = cd_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_timeout = timeout_q;
    assign state_dbg   = state;

endmodule
